// File: rtl/avg_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : avg_seq_ctrl
// Purpose  : Sequenced signed averager. Samples stream in over a valid/ready
//            port and are summed with one shared adder. The sum is then passed
//            NSHIFT times through one arithmetic right shifter by a latched
//            amount, and the low DATAW bits are offered on a valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module avg_seq_ctrl #(
  parameter int DATAW  = 16,
  parameter int ACCW   = 32,
  parameter int NSAMP  = 8,
  parameter int NSHIFT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  input  logic [7:0]       sa,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] avg,
  output logic             busy
);

  localparam int CNTW = $clog2(NSAMP + 1);
  localparam int SHW  = $clog2(NSHIFT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NSAMP - 1);
  localparam logic [SHW-1:0]  SH_LAST  = SHW'(NSHIFT - 1);

  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic signed [ACCW-1:0] acc;
  logic [CNTW-1:0]        cnt;
  logic [SHW-1:0]         shcnt;
  logic [7:0]             sa_l;

  logic                   accept;
  logic                   last_sample;
  logic                   last_shift;
  logic signed [ACCW-1:0] sample_ext;
  logic signed [ACCW-1:0] add_a;
  logic signed [ACCW-1:0] sum;
  logic signed [ACCW-1:0] acc_shifted;

  // Shared datapath: one adder (first sample adds to zero) and one shifter.
  always_comb begin
    sample_ext  = ACCW'($signed(in_data));
    add_a       = (state == S_ACCUM) ? acc : '0;
    sum         = add_a + sample_ext;
    acc_shifted = acc >>> sa_l;
    last_sample = (state == S_IDLE) ? (NSAMP == 1) : (cnt == CNT_LAST);
    last_shift  = (shcnt == SH_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; clr overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (accept) state_nxt = last_sample ? S_SHIFT : S_ACCUM;
        S_ACCUM: if (accept && last_sample) state_nxt = S_SHIFT;
        S_SHIFT: if (last_shift) state_nxt = S_DONE;
        S_DONE:  if (out_ready) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state only, plus the internal accept strobe.
  always_comb begin
    in_ready = (state == S_IDLE) || (state == S_ACCUM);
    busy     = (state != S_IDLE);
    accept   = in_valid && in_ready;
  end

  // Accumulator, counters, latched shift amount and result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      cnt       <= '0;
      shcnt     <= '0;
      sa_l      <= '0;
      avg       <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      acc       <= '0;
      cnt       <= '0;
      shcnt     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            acc   <= sum;
            cnt   <= CNTW'(1);
            sa_l  <= sa;
            shcnt <= '0;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            acc <= sum;
            cnt <= cnt + CNTW'(1);
            if (last_sample) shcnt <= '0;
          end
        end
        S_SHIFT: begin
          acc   <= acc_shifted;
          shcnt <= shcnt + SHW'(1);
          if (last_shift) begin
            avg       <= acc_shifted[DATAW-1:0];
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
